hex_display_module: RTL and testbench

Memory-mapped output peripheral driving four active-low seven-segment displays (HEX3..HEX0) from the processor's data/address bus; the write-side counterpart of the switch input device on the same bus. The CPU writes a 16-bit value to the data register and display controls to the control register. The block decodes each nibble to segments through a registered decoder. An optional blink timer periodically blanks the displays.

---
 rtl/hex_display_module.sv | 175 +++++++++++++++++
 tb/tb_hex_display_module.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/hex_display_module.sv
// hex_display_module: memory-mapped driver for four active-low seven-segment
// digits (hex3..hex0). A data register holds the 16-bit value to show and a
// control register holds blank, blink and per-digit enable controls. Each
// nibble is decoded through a registered stage, so segments follow register
// changes one clock later.
// Optional feature macro: HEX_BLINK_EN (enables the blink timer, BLINK and PHASE).
module hex_display_module #(
  parameter logic [31:0] HDATA     = 32'hF0000000,
  parameter logic [31:0] HCTRL     = 32'hF0000100,
  parameter int          BLINK_DIV = 25000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] abus,
  input  logic [31:0] dbus,
  input  logic        wren,
  output logic [31:0] dbusout,
  output logic [6:0]  hex0,
  output logic [6:0]  hex1,
  output logic [6:0]  hex2,
  output logic [6:0]  hex3
);

  logic [15:0] hex_reg;
  logic        blank;
  logic [3:0]  digen;
  logic        blink;
  logic        phase;
  logic        wr_data;
  logic        wr_ctrl;
  logic [6:0]  seg_p1 [4];
  logic        unused_dbus;

  assign wr_data     = wren && (abus == HDATA);
  assign wr_ctrl     = wren && (abus == HCTRL);
  assign unused_dbus = ^dbus[31:16];

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  // Register file: data value, blank flag and digit enables
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hex_reg <= 16'h0000;
      blank   <= 1'b0;
      digen   <= 4'hF;
    end else begin
      if (wr_data) begin
        hex_reg <= dbus[15:0];
      end
      if (wr_ctrl) begin
        blank <= dbus[0];
        digen <= dbus[11:8];
      end
    end
  end

`ifdef HEX_BLINK_EN
  localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);

  typedef enum logic {IDLE, RUN} blink_state_t;

  blink_state_t     state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             phase_nxt;

  // Blink timer state, half-period counter and phase
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      phase <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      phase <= phase_nxt;
    end
  end

  // Blink next-state: a write with BLINK=0 always returns to IDLE, a write
  // keeping BLINK=1 while running leaves the count undisturbed
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    phase_nxt = phase;
    case (state)
      IDLE: begin
        cnt_nxt   = '0;
        phase_nxt = 1'b0;
        if (wr_ctrl && dbus[1]) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (wr_ctrl && !dbus[1]) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          phase_nxt = 1'b0;
        end else if (cnt == CNT_LAST) begin
          cnt_nxt   = '0;
          phase_nxt = ~phase;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        phase_nxt = 1'b0;
      end
    endcase
  end

  assign blink = (state == RUN);
`else
  assign blink = 1'b0;
  assign phase = 1'b0;
`endif

  // Decode stage: each digit shows its nibble unless blanked or disabled
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        seg_p1[i] <= 7'h7F;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (blank || (blink && phase) || !digen[i]) begin
          seg_p1[i] <= 7'h7F;
        end else begin
          seg_p1[i] <= seg_decode(hex_reg[4*i +: 4]);
        end
      end
    end
  end

  assign hex0 = seg_p1[0];
  assign hex1 = seg_p1[1];
  assign hex2 = seg_p1[2];
  assign hex3 = seg_p1[3];

  // Read mux: combinational from registers, zero unless a read hits a register
  always_comb begin
    dbusout = 32'h0;
    if (!wren) begin
      if (abus == HDATA) begin
        dbusout = {16'h0, hex_reg};
      end else if (abus == HCTRL) begin
        dbusout = {20'h0, digen, 5'b0, phase, blink, blank};
      end
    end
  end

endmodule

// File: tb/tb_hex_display_module.sv
// tb_hex_display_module: table-driven bench for hex_display_module plus
// hand-written sequences for reset, back-to-back writes and blinking.
module tb_hex_display_module;

  localparam logic [31:0] HDATA = 32'hF0000000;
  localparam logic [31:0] HCTRL = 32'hF0000100;

  logic        clk;
  logic        reset;
  logic [31:0] abus;
  logic [31:0] dbus;
  logic        wren;
  logic [31:0] dbusout;
  logic [6:0]  hex0, hex1, hex2, hex3;

  int checks;
  int errors;

  hex_display_module #(
    .HDATA(HDATA),
    .HCTRL(HCTRL),
    .BLINK_DIV(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .abus(abus),
    .dbus(dbus),
    .wren(wren),
    .dbusout(dbusout),
    .hex0(hex0),
    .hex1(hex1),
    .hex2(hex2),
    .hex3(hex3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        is_ctrl;
    logic [31:0] wdata;
    logic [31:0] rd;
    logic [6:0]  h3, h2, h1, h0;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_digits(input string name, input logic [6:0] e3, input logic [6:0] e2,
                            input logic [6:0] e1, input logic [6:0] e0);
    chk({name, " hex3"}, {25'h0, hex3}, {25'h0, e3});
    chk({name, " hex2"}, {25'h0, hex2}, {25'h0, e2});
    chk({name, " hex1"}, {25'h0, hex1}, {25'h0, e1});
    chk({name, " hex0"}, {25'h0, hex0}, {25'h0, e0});
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    abus = a;
    dbus = d;
    wren = 1'b1;
    @(posedge clk);
    #1;
    wren = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    abus = a;
    wren = 1'b0;
    #1;
    d = dbusout;
  endtask

  initial begin
    logic [31:0] r;
    logic        ph, ph_prev;
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    abus   = 32'h0;
    dbus   = 32'h0;
    wren   = 1'b0;

    vecs[0] = '{1'b0, 32'hDEAD1A2F, 32'h00001A2F, 7'h79, 7'h08, 7'h24, 7'h0E};
    vecs[1] = '{1'b0, 32'h00000123, 32'h00000123, 7'h40, 7'h79, 7'h24, 7'h30};
    vecs[2] = '{1'b0, 32'h00004567, 32'h00004567, 7'h19, 7'h12, 7'h02, 7'h78};
    vecs[3] = '{1'b0, 32'h000089AB, 32'h000089AB, 7'h00, 7'h10, 7'h08, 7'h03};
    vecs[4] = '{1'b0, 32'h0000CDEF, 32'h0000CDEF, 7'h46, 7'h21, 7'h06, 7'h0E};
    vecs[5] = '{1'b1, 32'h00000501, 32'h00000501, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
    vecs[6] = '{1'b1, 32'h00000500, 32'h00000500, 7'h7F, 7'h21, 7'h7F, 7'h0E};
    vecs[7] = '{1'b1, 32'hFFFFFF00, 32'h00000F00, 7'h46, 7'h21, 7'h06, 7'h0E};
    vecs[8] = '{1'b0, 32'h00001A2F, 32'h00001A2F, 7'h79, 7'h08, 7'h24, 7'h0E};

    // Reset held, then released
    repeat (2) @(posedge clk);
    #1;
    chk_digits("in_reset", 7'h7F, 7'h7F, 7'h7F, 7'h7F);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk_digits("after_release", 7'h40, 7'h40, 7'h40, 7'h40);
    bus_read(HCTRL, r);
    chk("reset_hctrl", r, 32'h00000F00);
    bus_read(HDATA, r);
    chk("reset_hdata", r, 32'h0);

    // Table-driven register writes
    for (int i = 0; i < 9; i++) begin
      bus_write(vecs[i].is_ctrl ? HCTRL : HDATA, vecs[i].wdata);
      bus_read(vecs[i].is_ctrl ? HCTRL : HDATA, r);
      chk($sformatf("vec%0d read", i), r, vecs[i].rd);
      @(posedge clk);
      #1;
      chk_digits($sformatf("vec%0d", i), vecs[i].h3, vecs[i].h2, vecs[i].h1, vecs[i].h0);
    end

    // Unmapped reads and reads while writing return zero
    bus_read(32'h00000004, r);
    chk("unmapped_read", r, 32'h0);
    @(negedge clk);
    abus = HDATA;
    wren = 1'b1;
    dbus = 32'h00001A2F;
    #1;
    chk("read_during_write", dbusout, 32'h0);
    @(posedge clk);
    #1;
    wren = 1'b0;

    // Back-to-back writes, last one wins
    bus_write(HDATA, 32'h00001111);
    bus_write(HDATA, 32'h00002222);
    bus_read(HDATA, r);
    chk("b2b_read", r, 32'h00002222);
    chk_digits("b2b_first", 7'h79, 7'h79, 7'h79, 7'h79);
    @(posedge clk);
    #1;
    chk_digits("b2b_last", 7'h24, 7'h24, 7'h24, 7'h24);
    bus_write(HDATA, 32'h00001A2F);
    @(posedge clk);

`ifdef HEX_BLINK_EN
    // Blink start: PHASE toggles every 4 cycles, digits blank one edge later
    bus_write(HCTRL, 32'h00000F02);
    bus_read(HCTRL, r);
    chk("blink_start", r, 32'h00000F02);
    ph_prev = 1'b0;
    for (int j = 1; j <= 12; j++) begin
      @(posedge clk);
      #1;
      ph = ((j / 4) % 2) == 1;
      bus_read(HCTRL, r);
      chk($sformatf("blink_phase j%0d", j), r, ph ? 32'h00000F06 : 32'h00000F02);
      chk($sformatf("blink_hex0 j%0d", j), {25'h0, hex0}, ph_prev ? 32'h7F : 32'h0E);
      ph_prev = ph;
    end
    // Clear BLINK mid-count with PHASE=1
    repeat (2) @(posedge clk);
    bus_write(HCTRL, 32'h00000F00);
    bus_read(HCTRL, r);
    chk("blink_clear_read", r, 32'h00000F00);
    chk("blink_clear_hex0_old", {25'h0, hex0}, 32'h7F);
    @(posedge clk);
    #1;
    chk_digits("blink_clear_vis", 7'h79, 7'h08, 7'h24, 7'h0E);

    // Rewriting BLINK=1 while running keeps the count going
    bus_write(HCTRL, 32'h00000F02);
    repeat (2) @(posedge clk);
    bus_write(HCTRL, 32'h00000F02);
    bus_read(HCTRL, r);
    chk("keep_phase0", r, 32'h00000F02);
    @(posedge clk);
    #1;
    bus_read(HCTRL, r);
    chk("keep_phase1", r, 32'h00000F06);
    chk("keep_hex0_vis", {25'h0, hex0}, 32'h0E);
    @(posedge clk);
    #1;
    chk("keep_hex0_blank", {25'h0, hex0}, 32'h7F);
`else
    // Without the blink timer BLINK and PHASE stay zero
    bus_write(HCTRL, 32'h00000F06);
    bus_read(HCTRL, r);
    chk("noblink_read", r, 32'h00000F00);
    for (int j = 1; j <= 12; j++) begin
      @(posedge clk);
      #1;
      chk($sformatf("noblink_hex0 j%0d", j), {25'h0, hex0}, 32'h0E);
    end
    bus_write(HCTRL, 32'h00000F02);
    @(posedge clk);
    #1;
    chk_digits("noblink_vis", 7'h79, 7'h08, 7'h24, 7'h0E);
`endif

    // Asynchronous reset between clock edges
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk_digits("async_reset", 7'h7F, 7'h7F, 7'h7F, 7'h7F);
    @(negedge clk);
    reset = 1'b0;
    bus_read(HCTRL, r);
    chk("post_reset_hctrl", r, 32'h00000F00);
    bus_read(HDATA, r);
    chk("post_reset_hdata", r, 32'h0);
    @(posedge clk);
    #1;
    chk_digits("post_reset_digits", 7'h40, 7'h40, 7'h40, 7'h40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
